simmem_delay_releaser: RTL and testbench

// - Producer of the per-ID release enables consumed by the linked-list response bank.
// - Holds one timer slot per in-flight request: ID plus simulated latency in cycles.
// - Asserts release_en_o[id] while the oldest pending slot of that ID has expired.
// - Frees that slot when the bank reports a completed output handshake for the ID.

---
 rtl/simmem_delay_releaser.sv | 195 +++++++++++++++++++
 tb/tb_simmem_delay_releaser.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/simmem_delay_releaser.sv
// -----------------------------------------------------------------------------
// simmem_delay_releaser
//
// Purpose:
//   Produces the per-ID release enables consumed by the linked-list response
//   bank of the simulated memory. Each in-flight request occupies one timer
//   slot holding its ID and a down-counter loaded with the simulated latency.
//   release_en_o[id] is high while the oldest pending slot of that ID has
//   counted down to zero. The slot is freed when the bank reports a completed
//   output handshake for that ID.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   in_valid_i    new request timer valid
//   in_ready_o    a free slot exists (registered occupancy only)
//   in_id_i       request ID
//   in_delay_i    simulated latency in cycles
//   release_en_o  per-ID release enable, one bit per ID value
//   rel_valid_i   bank completed one output handshake this cycle
//   rel_id_i      ID of the released entry
//   occupancy_o   number of occupied slots
//   stall_cnt_o   (only with SIMMEM_RELEASER_STATS_EN) saturating count of
//                 cycles with in_valid_i && !in_ready_o
//
// Configuration:
//   SIMMEM_RELEASER_STATS_EN  when defined, adds stall_cnt_o and its counter.
// -----------------------------------------------------------------------------
module simmem_delay_releaser #(
    parameter int IDWidth    = 8,
    parameter int NumSlots   = 32,
    parameter int DelayWidth = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [IDWidth-1:0]          in_id_i,
    input  logic [DelayWidth-1:0]       in_delay_i,
    output logic [2**IDWidth-1:0]       release_en_o,
    input  logic                        rel_valid_i,
    input  logic [IDWidth-1:0]          rel_id_i,
    output logic [$clog2(NumSlots):0]   occupancy_o
`ifdef SIMMEM_RELEASER_STATS_EN
    ,
    output logic [31:0]                 stall_cnt_o
`endif
);

    localparam int OccW  = $clog2(NumSlots) + 1;
    localparam int SlotW = (NumSlots > 1) ? $clog2(NumSlots) : 1;

    // Slot state. older_q[i][j] = 1 means slot i was accepted before slot j.
    logic [NumSlots-1:0]    valid_q, valid_d;
    logic [IDWidth-1:0]     id_q    [NumSlots];
    logic [IDWidth-1:0]     id_d    [NumSlots];
    logic [DelayWidth-1:0]  cnt_q   [NumSlots];
    logic [DelayWidth-1:0]  cnt_d   [NumSlots];
    logic [NumSlots-1:0]    older_q [NumSlots];
    logic [NumSlots-1:0]    older_d [NumSlots];
    logic [OccW-1:0]        occupancy_q, occupancy_d;

    logic [NumSlots-1:0]    oldest;
    logic [NumSlots-1:0]    expired;
    logic [NumSlots-1:0]    free_hit;
    logic [NumSlots-1:0]    free_vec;
    logic                   free_ok;
    logic                   accept;
    logic                   alloc_found;
    logic [SlotW-1:0]       alloc_idx;
    logic [2**IDWidth-1:0]  release_en;

    // A slot is the oldest of its ID when no other valid slot with the same ID
    // is older. The age matrix keeps this independent of slot index order.
    always_comb begin
        oldest  = '0;
        expired = '0;
        for (int i = 0; i < NumSlots; i++) begin
            oldest[i]  = valid_q[i];
            expired[i] = valid_q[i] && (cnt_q[i] == '0);
            for (int j = 0; j < NumSlots; j++) begin
                if (j != i && valid_q[j] && (id_q[j] == id_q[i]) && older_q[j][i]) begin
                    oldest[i] = 1'b0;
                end
            end
        end
    end

    // Release enables come from registered slot state only.
    always_comb begin
        release_en = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (oldest[i] && expired[i]) begin
                release_en[id_q[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        free_hit = '0;
        for (int i = 0; i < NumSlots; i++) begin
            free_hit[i] = oldest[i] && expired[i] && (id_q[i] == rel_id_i);
        end
        free_ok  = rel_valid_i && (|free_hit);
        free_vec = free_ok ? free_hit : '0;
    end

    // Allocation searches the registered valid vector, so a slot freed this
    // cycle only becomes reusable next cycle.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = SlotW'(i);
            end
        end
    end

    assign in_ready_o   = (occupancy_q != OccW'(NumSlots));
    assign accept       = in_valid_i && in_ready_o;
    assign release_en_o = release_en;
    assign occupancy_o  = occupancy_q;

    always_comb begin
        valid_d = valid_q & ~free_vec;
        for (int i = 0; i < NumSlots; i++) begin
            id_d[i]    = id_q[i];
            older_d[i] = older_q[i];
            cnt_d[i]   = (valid_q[i] && (cnt_q[i] != '0)) ? cnt_q[i] - 1'b1 : cnt_q[i];
        end
        if (accept) begin
            valid_d[alloc_idx] = 1'b1;
            id_d[alloc_idx]    = in_id_i;
            cnt_d[alloc_idx]   = in_delay_i;
            older_d[alloc_idx] = '0;
            // Every slot currently valid is older than the newcomer; a slot
            // freed on this same edge carries a stale bit that is masked by
            // its valid flag until it is reallocated and overwritten.
            for (int j = 0; j < NumSlots; j++) begin
                older_d[j][alloc_idx] = valid_q[j];
            end
        end
        occupancy_d = occupancy_q + OccW'(accept) - OccW'(free_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= '0;
            occupancy_q <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                id_q[i]    <= '0;
                cnt_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            occupancy_q <= occupancy_d;
            for (int i = 0; i < NumSlots; i++) begin
                id_q[i]    <= id_d[i];
                cnt_q[i]   <= cnt_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

`ifdef SIMMEM_RELEASER_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid_i && !in_ready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    // A release for an ID whose oldest slot has not expired is a bank bug;
    // the state is left untouched in that case.
    rel_without_expired_slot : assert property (
        @(posedge clk_i) disable iff (!rst_ni) rel_valid_i |-> free_ok
    ) else $error("release for id %0d without an expired oldest slot", rel_id_i);

endmodule

// File: tb/tb_simmem_delay_releaser.sv
module tb_simmem_delay_releaser;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [7:0]   in_id_i;
    logic [7:0]   in_delay_i;
    logic [255:0] release_en_o;
    logic         rel_valid_i;
    logic [7:0]   rel_id_i;
    logic [5:0]   occupancy_o;
`ifdef SIMMEM_RELEASER_STATS_EN
    logic [31:0]  stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    simmem_delay_releaser dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_id_i      (in_id_i),
        .in_delay_i   (in_delay_i),
        .release_en_o (release_en_o),
        .rel_valid_i  (rel_valid_i),
        .rel_id_i     (rel_id_i),
        .occupancy_o  (occupancy_o)
`ifdef SIMMEM_RELEASER_STATS_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: pending requests in acceptance order. An entry is
    // releasable once the current cycle index reaches accept_edge + delay.
    typedef struct {
        int id;
        int exp_cyc;
    } ent_t;

    ent_t   pend[$];
    int     cyc   = 0;
    longint stall = 0;

    function automatic logic [255:0] model_rel();
        logic [255:0] seen;
        logic [255:0] r;
        seen = '0;
        r    = '0;
        foreach (pend[k]) begin
            if (!seen[pend[k].id]) begin
                seen[pend[k].id] = 1'b1;
                if (cyc >= pend[k].exp_cyc) r[pend[k].id] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic check_outputs();
        check_eq("occupancy", occupancy_o, pend.size());
        check_eq("in_ready", in_ready_o, pend.size() != 32);
        check_eq("release_en", release_en_o, model_rel());
`ifdef SIMMEM_RELEASER_STATS_EN
        check_eq("stall_cnt", stall_cnt_o, stall);
`endif
    endtask

    // One cycle: check outputs, pick random stimulus, apply it on the next
    // edge and advance the model.
    task automatic run_cycle(input int p_in, input int p_rel, input int id_max, input int dmax);
        logic [255:0] er;
        int           cand[$];
        int           d;
        bit           acc;
        @(negedge clk_i);
        check_outputs();
        er = model_rel();
        in_valid_i = ($urandom % 100) < p_in;
        in_id_i    = 8'($urandom_range(0, id_max));
        d          = (($urandom % 8) == 0) ? ((($urandom % 2) == 0) ? 0 : dmax)
                                           : $urandom_range(0, dmax);
        in_delay_i = 8'(d);
        for (int k = 0; k < 256; k++) if (er[k]) cand.push_back(k);
        rel_valid_i = (cand.size() != 0) && (($urandom % 100) < p_rel);
        rel_id_i    = rel_valid_i ? 8'(cand[$urandom_range(0, cand.size() - 1)]) : 8'd0;
        @(posedge clk_i);
        acc = in_valid_i && (pend.size() < 32);
        if (in_valid_i && pend.size() == 32) stall++;
        if (rel_valid_i) begin
            for (int k = 0; k < pend.size(); k++) begin
                if (pend[k].id == int'(rel_id_i)) begin
                    pend.delete(k);
                    break;
                end
            end
        end
        if (acc) pend.push_back('{id: int'(in_id_i), exp_cyc: cyc + 1 + d});
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        rel_valid_i = 1'b0;
        pend.delete();
        stall = 0;
        #1;
        check_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_id_i     = '0;
        in_delay_i  = '0;
        rel_valid_i = 1'b0;
        rel_id_i    = '0;
        #12;
        check_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // few IDs, short delays: heavy same-ID ordering
        repeat (400) run_cycle(30, 50, 3, 12);
        // wide ID space, medium delays
        repeat (400) run_cycle(40, 40, 255, 40);
        // fill to capacity, stall while full, then accept and free together
        repeat (45) run_cycle(100, 0, 7, 20);
        repeat (60) run_cycle(100, 100, 7, 20);
        repeat (40) run_cycle(0, 100, 7, 20);
        // about ten pending, then reset mid-operation
        repeat (10) run_cycle(100, 0, 15, 60);
        do_reset();
        repeat (200) run_cycle(50, 60, 5, 3);
        // long delays including the maximum
        repeat (1500) run_cycle(10, 80, 7, 255);
        // drain
        repeat (300) run_cycle(0, 100, 255, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
